online_mul_arbiter: RTL and testbench
=====================================

Name: online_mul_arbiter

Overview:
- Shares one digit-serial online multiplier among NREQ requesters, such as the Newton-iteration stages that each need x*y products.
- Grants the multiplier for one whole operation: NDIGITS input digit pairs in, NDIGITS product digits out.
- Arbitration is round-robin.
- Routes the granted requester's In_vd/In_rd and Out_vd/Out_rd handshakes to and from the multiplier with zero added latency.
- Sits between requester stages and a single multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NDIGITS, 8, digits per operation, both in and out (1..255).
- CNT_W, $clog2(NDIGITS+1), width of the digit counters.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_vd  in  NREQ  per-requester input digit valid
- req_x  in  2*NREQ  per-requester x digit, 2-bit signed digit; requester i at bits [2i+1:2i]
- req_y  in  2*NREQ  per-requester y digit, same packing
- req_rd  out  NREQ  per-requester input digit accepted
- res_vd  out  NREQ  per-requester product digit valid
- res_p  out  2  product digit, shared by all requesters; qualify with res_vd
- res_rd  in  NREQ  per-requester product digit taken
- mul_x, mul_y  out  2  digits to the multiplier
- mul_in_vd  out  1  multiplier input valid
- mul_in_rd  in  1  multiplier input ready
- mul_p  in  2  multiplier output digit
- mul_out_vd  in  1  multiplier output valid
- mul_out_rd  out  1  multiplier output ready
- grant  out  NREQ  one-hot current owner; all zero when idle
- busy  out  1  high in RUN
- err  out  1  sticky protocol error flag

Behaviour:
- Reset values (async on rst=1):
  - state=IDLE, ptr=0, gnt_idx=0, in_cnt=0, out_cnt=0, err=0.
  - All outputs 0: grant, busy, req_rd, res_vd, mul_in_vd, mul_out_rd, mul_x, mul_y, res_p.
- A digit transfers on a cycle where valid & ready are both high at the clock edge. Digits pass through unchanged; no re-encoding.
- States:
  - IDLE
  - RUN
  - REL (release)
- IDLE:
  - All handshakes deasserted.
  - If any req_vd bit is set, pick the first set index searching ptr, ptr+1, … mod NREQ.
  - Latch it in gnt_idx, clear both counters, go to RUN.
  - No digit is accepted in the IDLE cycle.
- RUN, with g = gnt_idx:
  - grant = onehot(g), busy = 1.
  - mul_x = req_x[g], mul_y = req_y[g].
  - mul_in_vd = req_vd[g] & (in_cnt < NDIGITS).
  - req_rd[g] = mul_in_rd & (in_cnt < NDIGITS); all other req_rd = 0.
  - Each input transfer increments in_cnt, which saturates at NDIGITS. Further req_vd[g] digits stall with req_rd[g] = 0.
  - res_p = mul_p; res_vd[g] = mul_out_vd; mul_out_rd = res_rd[g]; other res_vd = 0.
  - Each output transfer increments out_cnt.
  - The transfer that makes out_cnt == NDIGITS moves the FSM to REL.
- REL (exactly one cycle):
  - All handshakes 0.
  - ptr <= (gnt_idx+1) mod NREQ.
  - Go to IDLE.
  - Back-to-back grants are therefore separated by 2 idle cycles (REL, then IDLE).
- Ownership:
  - The grant is held for the full operation even if req_vd[g] drops mid-stream; the operation simply stalls.
  - Other requesters' req_vd are ignored during RUN/REL.
- Output digits may arrive before all inputs are delivered (online delay); in_cnt and out_cnt advance independently.
- Error handling:
  - mul_out_vd high in IDLE or REL: mul_out_rd stays 0 and err is set.
  - An output transfer in RUN while in_cnt == 0: err is set.
  - err clears only on rst.
- Reset mid-operation: immediate return to IDLE, ptr = 0, and the partial operation is discarded. The multiplier must be reset by the same rst; the arbiter does not flush it.
- No combinational path from mul_in_vd to mul_in_rd is assumed. The multiplier's ready outputs are registered, so there is no loop.

Decomposition:
- Package online_mul_pkg holds:
  - DIGIT_W = 2
  - State enum {IDLE=2'b00, RUN=2'b01, REL=2'b10}
  - Signed-digit constants SD_ZERO = 2'b00, SD_POS = 2'b10, SD_NEG = 2'b01
- One sub-module, rr_pick: purely combinational.
  - Inputs: NREQ-bit request vector and ptr.
  - Outputs: a found flag and the index of the first set bit at or after ptr, with wrap-around.
- The top level holds the FSM, the counters and the muxing.

Test Plan:
- Single request, NDIGITS=8:
  - Stimulus: req_vd[0] held high; multiplier ready always; online delay 3.
  - Response: grant=0001 one cycle after request; 8 input and 8 output transfers; REL; ptr=1; err=0.
- Fairness:
  - Stimulus: req_vd[1] and req_vd[3] both held high from reset.
  - Response: grant order 1, 3, 1, 3, with exactly 2 idle cycles between operations.
- Backpressure:
  - Stimulus: res_rd[g] low for 5 cycles mid-stream.
  - Response: mul_out_rd=0 for those 5 cycles; out_cnt frozen; resumes and completes with 8 digits, none lost or duplicated.
- Extra input:
  - Stimulus: requester keeps req_vd high after 8 digits.
  - Response: req_rd[g]=0 and mul_in_vd=0 after the 8th transfer; in_cnt stays 8.
- Stray output:
  - Stimulus: pulse mul_out_vd while in IDLE.
  - Response: mul_out_rd=0, err=1 and it stays 1 until rst.
- Reset mid-operation:
  - Stimulus: assert rst during RUN at in_cnt=4.
  - Response: all outputs 0 immediately (asynchronous); after release, the next grant goes to requester 0.

Source files
------------

// File: rtl/online_mul_pkg.sv
// Shared types and constants for the online multiplier arbiter.
// A digit is a 2-bit signed digit carried through without re-encoding.
package online_mul_pkg;

    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        REL  = 2'b10
    } state_e;

    localparam logic [DIGIT_W-1:0] SD_ZERO = 2'b00;
    localparam logic [DIGIT_W-1:0] SD_POS  = 2'b10;
    localparam logic [DIGIT_W-1:0] SD_NEG  = 2'b01;

endpackage

// File: rtl/online_mul_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after the
// pointer, wrapping past the top index back to zero.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_found,
    output logic [PTR_W-1:0] o_idx
);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_cand;

    // Walk offsets from the farthest down to zero so the nearest hit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NREQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NREQ);
            end else begin
                w_sum = w_sum;
            end
            w_cand = w_sum[PTR_W-1:0];
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end else begin
                o_found = o_found;
            end
        end
    end

endmodule

// File: rtl/online_mul_arbiter.sv
// Round-robin owner of one digit-serial online multiplier: a grant lasts
// one full operation and handshakes are routed with no added latency.
module online_mul_arbiter
    import online_mul_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int NDIGITS = 8,
    parameter int CNT_W   = $clog2(NDIGITS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_vd,
    input  logic [DIGIT_W*NREQ-1:0]   req_x,
    input  logic [DIGIT_W*NREQ-1:0]   req_y,
    output logic [NREQ-1:0]           req_rd,
    output logic [NREQ-1:0]           res_vd,
    output logic [DIGIT_W-1:0]        res_p,
    input  logic [NREQ-1:0]           res_rd,
    output logic [DIGIT_W-1:0]        mul_x,
    output logic [DIGIT_W-1:0]        mul_y,
    output logic                      mul_in_vd,
    input  logic                      mul_in_rd,
    input  logic [DIGIT_W-1:0]        mul_p,
    input  logic                      mul_out_vd,
    output logic                      mul_out_rd,
    output logic [NREQ-1:0]           grant,
    output logic                      busy,
    output logic                      err
);

    localparam int               PTR_W     = $clog2(NREQ);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(NDIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NDIGITS - 1);
    localparam logic [PTR_W-1:0] IDX_TOP   = PTR_W'(NREQ - 1);

    state_e             r_state;
    state_e             w_next_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_gnt_idx;
    logic [CNT_W-1:0]   r_in_cnt;
    logic [CNT_W-1:0]   r_out_cnt;
    logic               r_err;

    logic               w_found;
    logic [PTR_W-1:0]   w_pick;
    logic               w_run;
    logic               w_in_open;
    logic [NREQ-1:0]    w_onehot;
    logic [DIGIT_W-1:0] w_sel_x;
    logic [DIGIT_W-1:0] w_sel_y;
    logic               w_sel_vd;
    logic               w_sel_res_rd;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_last_out;
    logic               w_err_evt;
    logic [PTR_W-1:0]   w_ptr_next;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req   (req_vd),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_run      = (r_state == RUN);
    assign w_in_open  = (r_in_cnt < CNT_FULL);
    assign w_in_xfer  = mul_in_vd & mul_in_rd;
    assign w_out_xfer = mul_out_vd & mul_out_rd;
    assign w_last_out = w_out_xfer & (r_out_cnt == CNT_LAST);
    assign w_ptr_next = (r_gnt_idx == IDX_TOP) ? '0 : (r_gnt_idx + 1'b1);
    assign err        = r_err;

    // A stray output outside RUN, or a product digit before any input digit, is a protocol error.
    assign w_err_evt = (mul_out_vd & ~w_run) | (w_out_xfer & (r_in_cnt == '0));

    // Select the current owner's lanes.
    always_comb begin
        w_onehot     = '0;
        w_sel_x      = SD_ZERO;
        w_sel_y      = SD_ZERO;
        w_sel_vd     = 1'b0;
        w_sel_res_rd = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (PTR_W'(i) == r_gnt_idx) begin
                w_onehot[i]  = 1'b1;
                w_sel_x      = req_x[DIGIT_W*i +: DIGIT_W];
                w_sel_y      = req_y[DIGIT_W*i +: DIGIT_W];
                w_sel_vd     = req_vd[i];
                w_sel_res_rd = res_rd[i];
            end else begin
                w_onehot[i]  = 1'b0;
            end
        end
    end

    // Handshake routing; everything is quiet unless an operation is running.
    always_comb begin
        grant      = '0;
        busy       = 1'b0;
        req_rd     = '0;
        res_vd     = '0;
        res_p      = SD_ZERO;
        mul_x      = SD_ZERO;
        mul_y      = SD_ZERO;
        mul_in_vd  = 1'b0;
        mul_out_rd = 1'b0;
        if (w_run) begin
            grant      = w_onehot;
            busy       = 1'b1;
            mul_x      = w_sel_x;
            mul_y      = w_sel_y;
            mul_in_vd  = w_sel_vd & w_in_open;
            req_rd     = (mul_in_rd & w_in_open) ? w_onehot : '0;
            res_vd     = mul_out_vd ? w_onehot : '0;
            res_p      = mul_p;
            mul_out_rd = w_sel_res_rd;
        end else begin
            grant      = '0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (w_last_out) begin
                    w_next_state = REL;
                end else begin
                    w_next_state = RUN;
                end
            end
            REL:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Owner, pointer, digit counters and the sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            r_gnt_idx <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gnt_idx <= w_pick;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                    end
                end
                RUN: begin
                    if (w_in_xfer) begin
                        r_in_cnt <= r_in_cnt + 1'b1;
                    end
                    if (w_out_xfer) begin
                        r_out_cnt <= r_out_cnt + 1'b1;
                    end
                end
                REL: begin
                    r_ptr <= w_ptr_next;
                end
                default: begin
                    r_ptr <= r_ptr;
                end
            endcase
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_online_mul_arbiter.sv
// Self-checking bench: behavioural online multiplier, requester-side scoreboard,
// table of arbitration scenarios and hand-written corner sequences.
module tb_online_mul_arbiter;

    localparam int NREQ  = 4;
    localparam int ND    = 8;
    localparam int DELAY = 3;
    localparam int XW    = 2 * NREQ;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_vd;
    logic [XW-1:0]   req_x;
    logic [XW-1:0]   req_y;
    logic [NREQ-1:0] req_rd;
    logic [NREQ-1:0] res_vd;
    logic [1:0]      res_p;
    logic [NREQ-1:0] res_rd;
    logic [1:0]      mul_x;
    logic [1:0]      mul_y;
    logic            mul_in_vd;
    logic            mul_in_rd;
    logic [1:0]      mul_p;
    logic            mul_out_vd;
    logic            mul_out_rd;
    logic [NREQ-1:0] grant;
    logic            busy;
    logic            err;

    int n_chk = 0;
    int n_err = 0;
    int tot_in = 0;
    int tot_out = 0;

    always #5 clk = ~clk;

    online_mul_arbiter #(.NREQ(NREQ), .NDIGITS(ND)) dut (
        .clk(clk), .rst(rst),
        .req_vd(req_vd), .req_x(req_x), .req_y(req_y), .req_rd(req_rd),
        .res_vd(res_vd), .res_p(res_p), .res_rd(res_rd),
        .mul_x(mul_x), .mul_y(mul_y), .mul_in_vd(mul_in_vd), .mul_in_rd(mul_in_rd),
        .mul_p(mul_p), .mul_out_vd(mul_out_vd), .mul_out_rd(mul_out_rd),
        .grant(grant), .busy(busy), .err(err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Product-digit stand-in: any fixed map sensitive to both x and y.
    function automatic logic [1:0] pf(input logic [1:0] x, input logic [1:0] y);
        return x ^ {y[0], y[1]};
    endfunction

    // Behavioural multiplier: output digit j becomes available once more than
    // j+DELAY inputs arrived, or all inputs did.
    logic [1:0] mk_buf [0:255];
    int         mk_rx = 0;
    int         mk_tx = 0;
    logic       mk_vd;
    logic       stray;

    assign mk_vd      = (mk_tx < mk_rx) && ((mk_rx > mk_tx + DELAY) || (mk_rx == ND));
    assign mul_out_vd = mk_vd | stray;
    assign mul_p      = mk_vd ? mk_buf[mk_tx] : 2'b00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mk_rx <= 0;
            mk_tx <= 0;
        end else begin
            if (mul_in_vd && mul_in_rd && mk_rx < 256) begin
                mk_buf[mk_rx] <= pf(mul_x, mul_y);
                mk_rx <= mk_rx + 1;
            end
            if (mk_vd && mul_out_rd) begin
                if (mk_tx + 1 == ND) begin
                    mk_rx <= 0;
                    mk_tx <= 0;
                end else begin
                    mk_tx <= mk_tx + 1;
                end
            end
        end
    end

    // Scoreboard: push on requester-side input transfer, pop on result transfer.
    logic [4:0] sb_q [$];
    logic [4:0] sb_e;

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_vd[i] && req_rd[i]) begin
                    sb_q.push_back({3'(i), pf(req_x[2*i +: 2], req_y[2*i +: 2])});
                    tot_in++;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (res_vd[i] && res_rd[i]) begin
                    tot_out++;
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        sb_e = sb_q.pop_front();
                        chk("res_owner", i, int'(sb_e[4:2]));
                        chk("res_digit", int'(res_p), int'(sb_e[1:0]));
                    end
                end
            end
        end
    end

    // Requesters present fresh random digits every cycle.
    initial begin
        req_x = '0;
        req_y = '0;
        forever begin
            @(posedge clk);
            #1;
            req_x = XW'($urandom);
            req_y = XW'($urandom);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, " grant"}, int'(grant), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " req_rd"}, int'(req_rd), 0);
        chk({tag, " res_vd"}, int'(res_vd), 0);
        chk({tag, " mul_in_vd"}, int'(mul_in_vd), 0);
        chk({tag, " mul_out_rd"}, int'(mul_out_rd), 0);
        chk({tag, " mul_x"}, int'(mul_x), 0);
        chk({tag, " mul_y"}, int'(mul_y), 0);
        chk({tag, " res_p"}, int'(res_p), 0);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1 rst = 1'b1;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One full operation from IDLE; expects the grant one cycle after the request.
    task automatic run_op(input logic [NREQ-1:0] pat, input int exp_idx, input bit bp,
                          input int exp_err, input string tag);
        int b_in;
        int b_out;
        int cyc;
        int prev_in;
        bit bp_done;
        b_in    = tot_in;
        b_out   = tot_out;
        bp_done = 1'b0;
        prev_in = 0;
        cyc     = 0;
        @(posedge clk);
        #1 req_vd = pat;
        @(posedge clk);
        step();
        chk({tag, " grant"}, int'(grant), 1 << exp_idx);
        chk({tag, " busy"}, int'(busy), 1);
        while (busy && cyc < 300) begin
            if (prev_in == ND) begin
                chk({tag, " extra mul_in_vd"}, int'(mul_in_vd), 0);
                chk({tag, " extra req_rd"}, int'(req_rd), 0);
            end
            if (bp && !bp_done && (tot_out - b_out) == 3) begin
                bp_done = 1'b1;
                @(posedge clk);
                #1 res_rd = '0;
                for (int k = 0; k < 5; k++) begin
                    step();
                    chk({tag, " bp mul_out_rd"}, int'(mul_out_rd), 0);
                    chk({tag, " bp out frozen"}, tot_out - b_out, 3);
                end
                @(posedge clk);
                #1 res_rd = '1;
            end
            prev_in = tot_in - b_in;
            step();
            cyc++;
        end
        chk({tag, " completes"}, int'(cyc < 300), 1);
        chk({tag, " rel grant"}, int'(grant), 0);
        chk({tag, " in digits"}, tot_in - b_in, ND);
        chk({tag, " out digits"}, tot_out - b_out, ND);
        chk({tag, " sb empty"}, sb_q.size(), 0);
        chk({tag, " err"}, int'(err), exp_err);
        @(posedge clk);
        #1 req_vd = '0;
    endtask

    typedef struct {
        logic [NREQ-1:0] pat;
        int              exp_idx;
        bit              bp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int b_in;
        int b_out;
        int cyc;
        int idle;
        int seq [4];

        // Pointer walk from reset (ptr=0): each row's grant fixes the next pointer.
        tbl[0] = '{4'b0001, 0, 1'b0};
        tbl[1] = '{4'b1111, 1, 1'b0};
        tbl[2] = '{4'b0011, 0, 1'b1};
        tbl[3] = '{4'b1000, 3, 1'b0};
        tbl[4] = '{4'b0110, 1, 1'b0};
        tbl[5] = '{4'b0101, 2, 1'b1};
        tbl[6] = '{4'b1001, 3, 1'b0};
        tbl[7] = '{4'b1110, 1, 1'b0};
        seq[0] = 1; seq[1] = 3; seq[2] = 1; seq[3] = 3;

        rst       = 1'b1;
        req_vd    = '0;
        res_rd    = '1;
        mul_in_rd = 1'b1;
        stray     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        chk("reset err", int'(err), 0);
        #1 rst = 1'b0;

        for (int t = 0; t < 8; t++) begin
            run_op(tbl[t].pat, tbl[t].exp_idx, tbl[t].bp, 0, $sformatf("vec%0d", t));
        end

        // Fairness: requesters 1 and 3 held from reset.
        req_vd = 4'b1010;
        reset_dut();
        b_in  = tot_in;
        b_out = tot_out;
        step();
        for (int k = 0; k < 4; k++) begin
            idle = 0;
            cyc  = 0;
            while (grant == '0 && cyc < 50) begin
                idle++;
                cyc++;
                step();
            end
            chk($sformatf("fair grant%0d", k), int'(grant), 1 << seq[k]);
            if (k > 0) begin
                chk($sformatf("fair gap%0d", k), idle, 2);
            end
            cyc = 0;
            while (grant != '0 && cyc < 300) begin
                cyc++;
                step();
            end
            chk($sformatf("fair done%0d", k), int'(cyc < 300), 1);
        end
        @(posedge clk);
        #1 req_vd = '0;
        chk("fair in digits", tot_in - b_in, 4 * ND);
        chk("fair out digits", tot_out - b_out, 4 * ND);

        // Stray multiplier output while idle.
        @(posedge clk);
        #1 stray = 1'b1;
        step();
        chk("stray mul_out_rd", int'(mul_out_rd), 0);
        chk("stray res_vd", int'(res_vd), 0);
        chk("stray err before edge", int'(err), 0);
        @(posedge clk);
        #1 stray = 1'b0;
        step();
        chk("stray err", int'(err), 1);
        run_op(4'b0100, 2, 1'b0, 1, "after_stray");

        // Reset in the middle of an operation, after the 4th input digit.
        b_in = tot_in;
        @(posedge clk);
        #1 req_vd = 4'b0010;
        @(posedge clk);
        step();
        chk("midrst grant", int'(grant), 4'b0010);
        cyc = 0;
        while ((tot_in - b_in) < 4 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("midrst reached 4", tot_in - b_in, 4);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_quiet("midrst");
        chk("midrst err", int'(err), 0);
        sb_q.delete();
        req_vd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_op(4'b1111, 0, 1'b0, 0, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
